// File: rtl/m1553_pkg.sv
// Shared definitions for the MIL-STD-1553 word receiver: timing defaults,
// FSM state encoding and error codes.
package m1553_pkg;

  localparam int unsigned HB_DEF       = 4;
  localparam int unsigned SYNC_TOL_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC1 = 2'd1,
    ST_SYNC2 = 2'd2,
    ST_DATA  = 2'd3
  } state_t;

  localparam logic [1:0] ERR_MANCH = 2'b01;
  localparam logic [1:0] ERR_PAR   = 2'b10;

endpackage

// File: rtl/m1553_sync2.sv
// Two-flop synchronizer for a single asynchronous input, reset to 0.
module m1553_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q, s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/m1553_word_rx.sv
// Manchester II word receiver: sync detection, free-running mid-half-bit
// sampling of 16 data bits plus odd parity, VALID/ERR reporting.
module m1553_word_rx
  import m1553_pkg::*;
#(
  parameter int unsigned HB       = HB_DEF,
  parameter int unsigned SYNC_TOL = SYNC_TOL_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RXD,
  input  logic        RXE,
  output logic [15:0] DATA,
  output logic        CMD,
  output logic        VALID,
  output logic        ERR,
  output logic [1:0]  ERR_CODE,
  output logic        BUSY
);

  localparam int unsigned TW = $clog2(40 * HB);
  localparam logic [TW-1:0] ONE     = TW'(1);
  localparam logic [TW-1:0] RUN_MIN = TW'(3 * HB - SYNC_TOL);
  localparam logic [TW-1:0] RUN_MAX = TW'(3 * HB + SYNC_TOL);
  localparam logic [TW-1:0] HB_T    = TW'(HB);
  localparam logic [TW-1:0] HB2_T   = TW'(2 * HB);
  localparam logic [TW-1:0] FIRST_T = TW'(3 * HB + HB / 2);

  logic rxd_s, rxe_s;

  m1553_sync2 u_sync_rxd (.clk(CLK), .rst(RST), .d(RXD), .q(rxd_s));
  m1553_sync2 u_sync_rxe (.clk(CLK), .rst(RST), .d(RXE), .q(rxe_s));

  state_t        state_q, state_d;
  logic          rxd_p_q, rxd_p_d;
  logic          pol_q, pol_d;
  logic [TW-1:0] run_q, run_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [TW-1:0] samp_q, samp_d;
  logic          half_q, half_d;
  logic          first_q, first_d;
  logic [4:0]    bit_q, bit_d;
  logic [15:0]   shreg_q, shreg_d;
  logic          par_q, par_d;
  logic [15:0]   data_q, data_d;
  logic          cmd_q, cmd_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic [1:0]    code_q, code_d;
  logic [TW-1:0] run_nx;

  // run_nx is the length of the current level run ending at this cycle's predecessor
  assign run_nx = run_q + ONE;

  always_comb begin
    state_d = state_q;
    rxd_p_d = rxd_s;
    pol_d   = pol_q;
    run_d   = run_q;
    tcnt_d  = tcnt_q;
    samp_d  = samp_q;
    half_d  = half_q;
    first_d = first_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    data_d  = data_q;
    cmd_d   = cmd_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    code_d  = code_q;

    if (state_q != ST_IDLE && !rxe_s) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (rxe_s && (rxd_s != rxd_p_q)) begin
            state_d = ST_SYNC1;
            run_d   = '0;
            pol_d   = rxd_s;
          end
        end
        ST_SYNC1: begin
          if (rxd_s == pol_q) begin
            if (run_nx >= RUN_MAX) state_d = ST_IDLE;
            else                   run_d   = run_nx;
          end else if (run_nx >= RUN_MIN && run_nx <= RUN_MAX) begin
            state_d = ST_SYNC2;
            tcnt_d  = ONE;
          end else begin
            pol_d = rxd_s;
            run_d = '0;
          end
        end
        ST_SYNC2: begin
          tcnt_d = tcnt_q + ONE;
          if (tcnt_q == HB_T || tcnt_q == HB2_T) begin
            if (rxd_s == pol_q) begin
              state_d = ST_IDLE;
            end else if (tcnt_q == HB2_T) begin
              state_d = ST_DATA;
              samp_d  = FIRST_T;
              half_d  = 1'b0;
              bit_d   = '0;
              par_d   = 1'b0;
            end
          end
        end
        ST_DATA: begin
          tcnt_d = tcnt_q + ONE;
          if (tcnt_q == samp_q) begin
            samp_d = samp_q + HB_T;
            if (!half_q) begin
              first_d = rxd_s;
              half_d  = 1'b1;
            end else begin
              half_d = 1'b0;
              if (rxd_s == first_q) begin
                err_d   = 1'b1;
                code_d  = ERR_MANCH;
                state_d = ST_IDLE;
              end else if (bit_q == 5'd16) begin
                state_d = ST_IDLE;
                if ((par_q ^ first_q) == 1'b1) begin
                  valid_d = 1'b1;
                  data_d  = shreg_q;
                  cmd_d   = pol_q;
                end else begin
                  err_d  = 1'b1;
                  code_d = ERR_PAR;
                end
              end else begin
                par_d   = par_q ^ first_q;
                bit_d   = bit_q + 5'd1;
                shreg_d = {shreg_q[14:0], first_q};
              end
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      rxd_p_q <= 1'b0;
      pol_q   <= 1'b0;
      run_q   <= '0;
      tcnt_q  <= '0;
      samp_q  <= '0;
      half_q  <= 1'b0;
      first_q <= 1'b0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      cmd_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      rxd_p_q <= rxd_p_d;
      pol_q   <= pol_d;
      run_q   <= run_d;
      tcnt_q  <= tcnt_d;
      samp_q  <= samp_d;
      half_q  <= half_d;
      first_q <= first_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      data_q  <= data_d;
      cmd_q   <= cmd_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign DATA     = data_q;
  assign CMD      = cmd_q;
  assign VALID    = valid_q;
  assign ERR      = err_q;
  assign ERR_CODE = code_q;
  assign BUSY     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_m1553_word_rx.sv
// Self-checking bench for m1553_word_rx: Manchester word generator with a
// scoreboard of expected VALID/ERR pulses checked by a monitor.
module tb_m1553_word_rx;

  localparam int HB = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        RXD = 1'b0;
  logic        RXE = 1'b0;
  logic [15:0] DATA;
  logic        CMD, VALID, ERR, BUSY;
  logic [1:0]  ERR_CODE;

  m1553_word_rx #(.HB(HB), .SYNC_TOL(2)) dut (
    .CLK(CLK), .RST(RST), .RXD(RXD), .RXE(RXE),
    .DATA(DATA), .CMD(CMD), .VALID(VALID), .ERR(ERR),
    .ERR_CODE(ERR_CODE), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    bit          is_err;
    logic [15:0] data;
    logic        cmd;
    logic [1:0]  code;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          errors = 0;
  int          checks = 0;
  logic [15:0] mdl_data = '0;
  logic        mdl_cmd  = 1'b0;
  logic [1:0]  mdl_code = 2'b00;
  bit          busy_next = 0;

  // Monitor: every pulse must match the head of the scoreboard.
  initial begin : monitor
    forever begin
      @(negedge CLK);
      if (busy_next) begin
        busy_next = 0;
        checks++;
        if (BUSY !== 1'b0) begin
          errors++;
          $display("FAIL busy_after_pulse BUSY=%b required 0 cycle %0d", BUSY, cyc);
        end
      end
      if (VALID === 1'b1 || ERR === 1'b1) begin
        busy_next = 1;
        checks++;
        if (VALID === 1'b1 && ERR === 1'b1) begin
          errors++;
          $display("FAIL valid_err_overlap VALID=1 ERR=1 required not both, cycle %0d", cyc);
        end
        checks++;
        if (BUSY !== 1'b0) begin
          errors++;
          $display("FAIL busy_at_pulse BUSY=%b required 0 cycle %0d", BUSY, cyc);
        end
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse VALID=%b ERR=%b required no pulse, cycle %0d", VALID, ERR, cyc);
        end else begin
          e = sb.pop_front();
          checks++;
          if (ERR !== e.is_err) begin
            errors++;
            $display("FAIL pulse_kind ERR=%b VALID=%b required ERR=%b", ERR, VALID, e.is_err);
          end
          checks++;
          if (cyc != e.cyc) begin
            errors++;
            $display("FAIL pulse_time cycle=%0d required %0d", cyc, e.cyc);
          end
          if (e.is_err) begin
            checks++;
            if (ERR_CODE !== e.code) begin
              errors++;
              $display("FAIL err_code ERR_CODE=%b required %b", ERR_CODE, e.code);
            end
            checks++;
            if (DATA !== mdl_data || CMD !== mdl_cmd) begin
              errors++;
              $display("FAIL err_hold DATA=%h CMD=%b required DATA=%h CMD=%b", DATA, CMD, mdl_data, mdl_cmd);
            end
            mdl_code = e.code;
          end else begin
            checks++;
            if (DATA !== e.data) begin
              errors++;
              $display("FAIL valid_data DATA=%h required %h", DATA, e.data);
            end
            checks++;
            if (CMD !== e.cmd) begin
              errors++;
              $display("FAIL valid_cmd CMD=%b required %b", CMD, e.cmd);
            end
            checks++;
            if (ERR_CODE !== mdl_code) begin
              errors++;
              $display("FAIL code_hold ERR_CODE=%b required %b", ERR_CODE, mdl_code);
            end
            mdl_data = e.data;
            mdl_cmd  = e.cmd;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  // Hold one level for n cycles; start = cycle index after whose edge it was driven.
  task automatic drive_lvl(input logic v, input int n, input logic rxe, input logic rst,
                           output int start);
    @(posedge CLK);
    #1;
    RXD = v;
    RXE = rxe;
    RST = rst;
    start = cyc;
    repeat (n - 1) @(posedge CLK);
  endtask

  // exp_kind: 0 none, 1 VALID, 2 Manchester ERR, 3 parity ERR.
  // abort_kind: 1 drop RXE from abort_bit onward, 2 pulse RST during abort_bit.
  task automatic send_word(input logic cmd, input logic [15:0] data, input logic par,
                           input int bad_bit, input int abort_bit, input int abort_kind,
                           input int gap, input int exp_kind, output int d);
    int   s;
    logic b, rxe, rst;
    exp_t x;
    if (gap > 0) drive_lvl(~cmd, gap, 1'b1, 1'b0, s);
    drive_lvl(cmd, 3 * HB, 1'b1, 1'b0, s);
    drive_lvl(~cmd, 3 * HB, 1'b1, 1'b0, d);
    if (exp_kind != 0) begin
      x.is_err = (exp_kind != 1);
      x.data   = data;
      x.cmd    = cmd;
      x.code   = (exp_kind == 2) ? 2'b01 : 2'b10;
      x.cyc    = (exp_kind == 2) ? d + 2 + 3 * HB + 2 * bad_bit * HB + HB / 2 + HB + 1
                                 : d + 2 + 36 * HB + HB / 2 + 1;
      sb.push_back(x);
    end
    rxe = 1'b1;
    for (int k = 0; k < 17; k++) begin
      if (k < 16) b = data[15 - k];
      else        b = par;
      if (k == abort_bit && abort_kind == 1) rxe = 1'b0;
      rst = (k == abort_bit && abort_kind == 2);
      drive_lvl(b, HB, rxe, rst, s);
      drive_lvl((k == bad_bit) ? b : ~b, HB, rxe, 1'b0, s);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    RXE = 1'b0;
    RXD = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++; if (DATA !== 16'h0000) begin errors++; $display("FAIL reset_data DATA=%h required 0000", DATA); end
    checks++; if (CMD !== 1'b0) begin errors++; $display("FAIL reset_cmd CMD=%b required 0", CMD); end
    checks++; if (VALID !== 1'b0) begin errors++; $display("FAIL reset_valid VALID=%b required 0", VALID); end
    checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL reset_err ERR=%b required 0", ERR); end
    checks++; if (ERR_CODE !== 2'b00) begin errors++; $display("FAIL reset_code ERR_CODE=%b required 00", ERR_CODE); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy BUSY=%b required 0", BUSY); end
    @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  task automatic test_cmd_word();
    int d;
    send_word(1'b1, 16'hA5C3, 1'b1, -1, -1, 0, 24, 1, d);
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge CLK);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL cmd_word_timeout pending=%0d required 0", sb.size()); sb.delete(); end
    repeat (10) @(negedge CLK);
    checks++;
    if (DATA !== 16'hA5C3 || ERR_CODE !== 2'b00) begin
      errors++; $display("FAIL cmd_word_stable DATA=%h ERR_CODE=%b required A5C3 00", DATA, ERR_CODE);
    end
  endtask

  task automatic test_data_word();
    int d;
    send_word(1'b0, 16'h0000, 1'b1, -1, -1, 0, 24, 1, d);
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge CLK);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL data_word_timeout pending=%0d required 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_parity_err();
    int d;
    send_word(1'b1, 16'hFFFF, 1'b0, -1, -1, 0, 24, 3, d);
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge CLK);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL parity_timeout pending=%0d required 0", sb.size()); sb.delete(); end
    repeat (5) @(negedge CLK);
    checks++;
    if (DATA !== 16'h0000 || ERR_CODE !== 2'b10) begin
      errors++; $display("FAIL parity_hold DATA=%h ERR_CODE=%b required 0000 10", DATA, ERR_CODE);
    end
  endtask

  task automatic test_manch_err();
    int d;
    send_word(1'b1, 16'h5555, 1'b1, 5, -1, 0, 24, 2, d);
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge CLK);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL manch_timeout pending=%0d required 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_sync_tol();
    int s, d;
    drive_lvl(1'b0, 24, 1'b1, 1'b0, s);
    drive_lvl(1'b1, 8, 1'b1, 1'b0, s);
    drive_lvl(1'b0, 16, 1'b1, 1'b0, s);
    send_word(1'b1, 16'h3C96, 1'b1, -1, -1, 0, 0, 1, d);
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge CLK);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sync_tol_timeout pending=%0d required 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_rxe_abort();
    int d;
    send_word(1'b0, 16'h1234, 1'b0, -1, 9, 1, 24, 0, d);
    @(negedge CLK);
    checks++;
    if (BUSY !== 1'b0) begin errors++; $display("FAIL rxe_abort_busy BUSY=%b required 0", BUSY); end
    send_word(1'b0, 16'h0F0F, 1'b1, -1, -1, 0, 24, 1, d);
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge CLK);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL rxe_abort_timeout pending=%0d required 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_rst_abort();
    int d;
    send_word(1'b1, 16'h8001, 1'b1, -1, 9, 2, 24, 0, d);
    mdl_data = '0;
    mdl_cmd  = 1'b0;
    mdl_code = 2'b00;
    repeat (5) @(negedge CLK);
    checks++;
    if (DATA !== 16'h0000 || CMD !== 1'b0 || ERR_CODE !== 2'b00) begin
      errors++; $display("FAIL rst_abort_clear DATA=%h CMD=%b ERR_CODE=%b required 0000 0 00", DATA, CMD, ERR_CODE);
    end
    send_word(1'b1, 16'hA5C3, 1'b1, -1, -1, 0, 24, 1, d);
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge CLK);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL rst_abort_timeout pending=%0d required 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_back_to_back();
    int d;
    send_word(1'b1, 16'hC3A5, 1'b1, -1, -1, 0, 24, 1, d);
    send_word(1'b1, 16'h0F0F, 1'b1, -1, -1, 0, 0, 1, d);
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge CLK);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL b2b_timeout pending=%0d required 0", sb.size()); sb.delete(); end
  endtask

  initial begin
    test_reset();
    test_cmd_word();
    test_data_word();
    test_parity_err();
    test_manch_err();
    test_sync_tol();
    test_rxe_abort();
    test_rst_abort();
    test_back_to_back();
    repeat (40) @(negedge CLK);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL final_queue pending=%0d required 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
